// File: rtl/kpn_sink_queue_pkg.sv
// Shared defaults and helpers for the KPN sink queue slice.
package kpn_queue_pkg;

   localparam int unsigned BITS_NUMBER_DEFAULT   = 16;
   localparam int unsigned FIFO_ELEMENTS_DEFAULT = 5;

   typedef logic [BITS_NUMBER_DEFAULT-1:0] token_t;

   function automatic int unsigned depth(input int unsigned fifo_elements);
      return 32'd1 << fifo_elements;
   endfunction

endpackage

// File: rtl/kpn_sink_queue_if.sv
// Channel bundle between the upstream writer / downstream reader and the sink queue.
interface kpn_sink_queue_if
   import kpn_queue_pkg::*;
#(
   parameter int unsigned BITS_NUMBER   = BITS_NUMBER_DEFAULT,
   parameter int unsigned FIFO_ELEMENTS = FIFO_ELEMENTS_DEFAULT
);
   logic                   wr;
   logic [BITS_NUMBER-1:0] input_1;
   logic                   rd;
   logic [BITS_NUMBER-1:0] output_1;
   logic                   valid;
   logic                   empty;
   logic                   full;
   logic [FIFO_ELEMENTS:0] count;
   logic                   overflow;
   logic                   underflow;

   modport master (
      output wr, input_1, rd,
      input  output_1, valid, empty, full, count, overflow, underflow
   );

   modport slave (
      input  wr, input_1, rd,
      output output_1, valid, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/kpn_sink_queue_mem.sv
// Token storage: synchronous write port, asynchronous read port, no reset.
module kpn_queue_mem
   import kpn_queue_pkg::*;
#(
   parameter int unsigned BITS_NUMBER   = BITS_NUMBER_DEFAULT,
   parameter int unsigned FIFO_ELEMENTS = FIFO_ELEMENTS_DEFAULT
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [FIFO_ELEMENTS-1:0] waddr,
   input  logic [BITS_NUMBER-1:0]   wdata,
   input  logic [FIFO_ELEMENTS-1:0] raddr,
   output logic [BITS_NUMBER-1:0]   rdata
);
   logic [BITS_NUMBER-1:0] mem [0:depth(FIFO_ELEMENTS)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/kpn_sink_queue.sv
// KPN channel sink: buffers upstream tokens and serves them to the downstream process on rd.
module kpn_sink_queue
   import kpn_queue_pkg::*;
#(
   parameter int unsigned BITS_NUMBER   = BITS_NUMBER_DEFAULT,
   parameter int unsigned FIFO_ELEMENTS = FIFO_ELEMENTS_DEFAULT
) (
   input logic             clk,
   input logic             rst_n,
   kpn_sink_queue_if.slave q
);
   localparam logic [FIFO_ELEMENTS-1:0] PTR_ONE   = FIFO_ELEMENTS'(1);
   localparam logic [FIFO_ELEMENTS:0]   CNT_ONE   = (FIFO_ELEMENTS+1)'(1);
   localparam logic [FIFO_ELEMENTS:0]   DEPTH_CNT = (FIFO_ELEMENTS+1)'(depth(FIFO_ELEMENTS));

   logic [FIFO_ELEMENTS-1:0] w_ptr, r_ptr;
   logic [FIFO_ELEMENTS:0]   cnt, cnt_next;
   logic [BITS_NUMBER-1:0]   rd_data, out_q;
   logic                     valid_q, empty_q, full_q, ovf_q, unf_q;
   logic                     do_wr, do_rd;

   // A write into a full queue still lands when the same-edge read frees a slot.
   always_comb begin
      do_rd    = q.rd && !empty_q;
      do_wr    = q.wr && (!full_q || q.rd);
      cnt_next = cnt;
      if (do_wr && !do_rd)      cnt_next = cnt + CNT_ONE;
      else if (do_rd && !do_wr) cnt_next = cnt - CNT_ONE;
   end

   kpn_queue_mem #(
      .BITS_NUMBER   (BITS_NUMBER),
      .FIFO_ELEMENTS (FIFO_ELEMENTS)
   ) u_mem (
      .clk   (clk),
      .we    (do_wr),
      .waddr (w_ptr),
      .wdata (q.input_1),
      .raddr (r_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr   <= '0;
         r_ptr   <= '0;
         cnt     <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         if (do_wr) w_ptr <= w_ptr + PTR_ONE;
         if (do_rd) begin
            r_ptr <= r_ptr + PTR_ONE;
            out_q <= rd_data;
         end
         valid_q <= do_rd;
         cnt     <= cnt_next;
         empty_q <= (cnt_next == '0);
         full_q  <= (cnt_next == DEPTH_CNT);
         if (q.wr && !do_wr) ovf_q <= 1'b1;
         if (q.rd && !do_rd) unf_q <= 1'b1;
      end
   end

   assign q.output_1  = out_q;
   assign q.valid     = valid_q;
   assign q.empty     = empty_q;
   assign q.full      = full_q;
   assign q.count     = cnt;
   assign q.overflow  = ovf_q;
   assign q.underflow = unf_q;
endmodule

// File: tb/tb_kpn_sink_queue.sv
// Directed and randomized checks of kpn_sink_queue against a queue-based reference model.
module tb_kpn_sink_queue;
   localparam int unsigned BN    = 16;
   localparam int unsigned FE    = 5;
   localparam int unsigned DEPTH = 32;

   logic clk;
   logic rst_n;
   int unsigned vectors;
   int unsigned miscompares;

   logic [BN-1:0] mq[$];
   logic [BN-1:0] m_out;
   logic          m_valid, m_ovf, m_unf;

   kpn_sink_queue_if #(.BITS_NUMBER(BN), .FIFO_ELEMENTS(FE)) bus ();

   kpn_sink_queue #(.BITS_NUMBER(BN), .FIFO_ELEMENTS(FE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".output_1"},  32'(bus.output_1),  32'(m_out));
      chk({tag, ".valid"},     32'(bus.valid),     32'(m_valid));
      chk({tag, ".count"},     32'(bus.count),     mq.size());
      chk({tag, ".empty"},     32'(bus.empty),     32'(mq.size() == 0));
      chk({tag, ".full"},      32'(bus.full),      32'(mq.size() == DEPTH));
      chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
      chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
   endtask

   task automatic model_reset();
      mq.delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   // One clock: drive, clock, then update the model from the pre-edge occupancy and compare.
   task automatic step(input string tag, input logic w, input logic [BN-1:0] d, input logic r);
      int unsigned pre;
      logic rok, wok;
      bus.wr      = w;
      bus.input_1 = d;
      bus.rd      = r;
      @(posedge clk);
      #1;
      pre = mq.size();
      rok = r && (pre != 0);
      wok = w && ((pre < DEPTH) || r);
      m_valid = rok;
      if (rok) m_out = mq.pop_front();
      if (r && !rok) m_unf = 1'b1;
      if (w && !wok) m_ovf = 1'b1;
      if (wok) mq.push_back(d);
      check_all(tag);
      bus.wr = 1'b0;
      bus.rd = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.wr      = 1'b0;
      bus.rd      = 1'b0;
      bus.input_1 = '0;
      model_reset();

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check_all("reset");
      step("idle", 1'b0, 16'h0000, 1'b0);

      for (int i = 1; i <= 4; i++) step("wr4", 1'b1, 16'(i), 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step("rd4", 1'b0, 16'h0000, 1'b1);
         chk("rd4.seq", 32'(bus.output_1), 32'(i));
      end

      for (int i = 0; i < 32; i++) step("fill", 1'b1, 16'h0100 + 16'(i), 1'b0);
      step("drop", 1'b1, 16'hDEAD, 1'b0);
      chk("drop.overflow", 32'(bus.overflow), 32'd1);
      for (int i = 0; i < 32; i++) begin
         step("drain", 1'b0, 16'h0000, 1'b1);
         chk("drain.seq", 32'(bus.output_1), 32'h0100 + 32'(i));
      end

      for (int i = 0; i < 32; i++) step("fill2", 1'b1, 16'h0200 + 16'(i), 1'b0);
      step("full_wr_rd", 1'b1, 16'hBEEF, 1'b1);
      chk("full_wr_rd.out", 32'(bus.output_1), 32'h0200);
      for (int i = 0; i < 32; i++) step("drain2", 1'b0, 16'h0000, 1'b1);
      chk("beef_last", 32'(bus.output_1), 32'h0000BEEF);

      step("empty_wr_rd", 1'b1, 16'h00AA, 1'b1);
      chk("empty_wr_rd.underflow", 32'(bus.underflow), 32'd1);
      step("empty_next_rd", 1'b0, 16'h0000, 1'b1);
      chk("empty_next_rd.out", 32'(bus.output_1), 32'h00AA);

      for (int i = 0; i < 300; i++)
         step("rand", ($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 9) < 5));

      for (int i = 0; i < 40 && mq.size() > 0; i++) step("flush", 1'b0, 16'h0000, 1'b1);
      step("stream_prime", 1'b1, 16'h3000, 1'b0);
      for (int i = 1; i <= 40; i++) step("stream", 1'b1, 16'h3000 + 16'(i), 1'b1);
      chk("stream.last_out", 32'(bus.output_1), 32'h3027);

      for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 16'($urandom), 1'b0);
      chk("pre_rst.count", 32'(bus.count), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #2 rst_n = 1'b1;
      step("post_rst", 1'b0, 16'h0000, 1'b0);
      step("post_rst_wr", 1'b1, 16'h0055, 1'b0);
      step("post_rst_rd", 1'b0, 16'h0000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
